// File: rtl/rv64_pkg.sv
// Shared RV64I definitions: major opcodes, immediate formats and the
// register-file write-enable decode used by decode and control.
package rv64_pkg;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // Only instructions that produce a result write back, and x0 is never a target.
  function automatic logic rf_write_en(input logic [6:0] op, input logic [4:0] rd);
    logic en;
    case (op)
      OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR, OP_32, OP_IMM_32: en = (rd != 5'd0);
      default: en = 1'b0;
    endcase
    return en;
  endfunction

  function automatic imm_type_e imm_type(input logic [6:0] op);
    imm_type_e t;
    case (op)
      LOAD, OP_IMM, OP_IMM_32, JALR: t = IMM_I;
      STORE:                         t = IMM_S;
      BRANCH:                        t = IMM_B;
      LUI, AUIPC:                    t = IMM_U;
      JAL:                           t = IMM_J;
      default:                       t = IMM_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x64 integer register file: three combinational read ports with
// write-through bypass, one write port, asynchronous active-low clear.
module regfile
  import rv64_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic [4:0]  raddr_ctl,
  input  logic [4:0]  waddr,
  input  logic [63:0] wdata,
  input  logic [6:0]  wopcode,
  output logic [63:0] rdata1,
  output logic [63:0] rdata2,
  output logic [63:0] rdata_ctl
);

  logic [63:0] regs_r  [32];
  logic        we_s;
  logic [4:0]  raddr_s [3];
  logic [63:0] rdata_s [3];

  assign we_s       = rf_write_en(wopcode, waddr) & rst;
  assign raddr_s[0] = raddr1;
  assign raddr_s[1] = raddr2;
  assign raddr_s[2] = raddr_ctl;
  assign rdata1     = rdata_s[0];
  assign rdata2     = rdata_s[1];
  assign rdata_ctl  = rdata_s[2];

  // Register storage: cleared immediately on reset, written on the rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 64'd0;
      end
    end else if (we_s) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Read ports: reset and x0 force zero; a same-cycle write is forwarded.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdata_s[p] = 64'd0;
      if (!rst || (raddr_s[p] == 5'd0)) begin
        rdata_s[p] = 64'd0;
      end else if (we_s && (waddr == raddr_s[p])) begin
        rdata_s[p] = wdata;
      end else begin
        rdata_s[p] = regs_r[raddr_s[p]];
      end
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV64I instruction-decode stage: field slicing, immediate generation and
// the integer register file.
module id_stage
  import rv64_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [63:0] wdata,
  input  logic [4:0]  wrd,
  input  logic [6:0]  wopcode,
  input  logic [4:0]  rs1_addr_control,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [63:0] data1,
  output logic [63:0] data2,
  output logic [63:0] imm_ext,
  output logic [63:0] rs1_data_control
);

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign func3  = inst[14:12];
  assign func7  = inst[31:25];

  regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .raddr1    (inst[19:15]),
    .raddr2    (inst[24:20]),
    .raddr_ctl (rs1_addr_control),
    .waddr     (wrd),
    .wdata     (wdata),
    .wopcode   (wopcode),
    .rdata1    (data1),
    .rdata2    (data2),
    .rdata_ctl (rs1_data_control)
  );

  // Immediate assembly by format; every format sign-extends from inst[31].
  always_comb begin
    imm_ext = 64'd0;
    case (imm_type(inst[6:0]))
      IMM_I:   imm_ext = {{52{inst[31]}}, inst[31:20]};
      IMM_S:   imm_ext = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm_ext = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm_ext = {{32{inst[31]}}, inst[31:12], 12'd0};
      IMM_J:   imm_ext = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm_ext = 64'd0;
    endcase
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [63:0] wdata;
  logic [4:0]  wrd;
  logic [6:0]  wopcode;
  logic [4:0]  rs1_addr_control;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [63:0] data1;
  logic [63:0] data2;
  logic [63:0] imm_ext;
  logic [63:0] rs1_data_control;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [6:0] WR_OPS [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                                        7'b0010111, 7'b1101111, 7'b1100111, 7'b0111011,
                                        7'b0011011};
  localparam logic [6:0] ALL_OPS [13] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                                          7'b0010111, 7'b1101111, 7'b1100111, 7'b0111011,
                                          7'b0011011, 7'b0100011, 7'b1100011, 7'b1111111,
                                          7'b0001111};

  logic [63:0] ref_regs [32];

  id_stage dut (
    .clk(clk), .rst(rst), .inst(inst), .wdata(wdata), .wrd(wrd), .wopcode(wopcode),
    .rs1_addr_control(rs1_addr_control), .opcode(opcode), .rd(rd), .func3(func3),
    .func7(func7), .data1(data1), .data2(data2), .imm_ext(imm_ext),
    .rs1_data_control(rs1_data_control)
  );

  always #5 clk = ~clk;

  function automatic bit ref_we(input logic [6:0] op, input logic [4:0] d);
    bit hit = 1'b0;
    for (int i = 0; i < 9; i++) if (WR_OPS[i] == op) hit = 1'b1;
    return hit && (d != 5'd0);
  endfunction

  function automatic logic [63:0] ref_read(input logic [4:0] a);
    if (rst !== 1'b1 || a == 5'd0) return 64'd0;
    if (ref_we(wopcode, wrd) && wrd == a) return wdata;
    return ref_regs[a];
  endfunction

  // Immediate value computed arithmetically from the bit positions of each format.
  function automatic logic [63:0] ref_imm(input logic [31:0] i);
    longint s;
    longint v;
    longint neg;
    s = longint'($signed(i));
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: v = s >>> 20;
      7'b0100011: v = ((s >>> 25) <<< 5) + longint'((i >> 7) & 32'd31);
      7'b1100011: begin
        neg = i[31] ? 64'sd4096 : 64'sd0;
        v = longint'(((i >> 8) & 32'd15) * 32'd2 + ((i >> 25) & 32'd63) * 32'd32
                     + ((i >> 7) & 32'd1) * 32'd2048) - neg;
      end
      7'b0110111, 7'b0010111: v = s - longint'(i & 32'hFFF);
      7'b1101111: begin
        neg = i[31] ? 64'sd1048576 : 64'sd0;
        v = longint'(((i >> 21) & 32'd1023) * 32'd2 + ((i >> 20) & 32'd1) * 32'd2048
                     + ((i >> 12) & 32'd255) * 32'd4096) - neg;
      end
      default: v = 64'sd0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] r_inst(input logic [4:0] a1, input logic [4:0] a2);
    return {7'd0, a2, a1, 3'd0, 5'd0, 7'b0110011};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst === 1'b1 && ref_we(wopcode, wrd)) ref_regs[wrd] = wdata;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    inst = 32'd0; wdata = 64'd0; wrd = 5'd0; wopcode = 7'd0; rs1_addr_control = 5'd0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 64'd0;
    @(negedge clk);
    inst = r_inst(5'd1, 5'd2); rs1_addr_control = 5'd3;
    #1;
    n_vec++;
    if (data1 !== 64'd0 || data2 !== 64'd0 || rs1_data_control !== 64'd0) begin
      n_err++;
      $display("FAIL reset_initial got %h %h %h want 0", data1, data2, rs1_data_control);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_random(input int n);
    logic [63:0] e1, e2, ec, ei;
    for (int k = 0; k < n; k++) begin
      inst = $urandom;
      inst[6:0] = ALL_OPS[$urandom_range(0, 12)];
      wrd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) wrd = inst[19:15];
      wdata = {$urandom, $urandom};
      wopcode = ALL_OPS[$urandom_range(0, 12)];
      rs1_addr_control = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) rs1_addr_control = wrd;
      #1;
      e1 = ref_read(5'((inst >> 15) % 32));
      e2 = ref_read(5'((inst >> 20) % 32));
      ec = ref_read(rs1_addr_control);
      ei = ref_imm(inst);
      n_vec++;
      if (data1 !== e1) begin n_err++; $display("FAIL rand_data1 k=%0d got %h want %h", k, data1, e1); end
      n_vec++;
      if (data2 !== e2) begin n_err++; $display("FAIL rand_data2 k=%0d got %h want %h", k, data2, e2); end
      n_vec++;
      if (rs1_data_control !== ec) begin n_err++; $display("FAIL rand_ctl k=%0d got %h want %h", k, rs1_data_control, ec); end
      n_vec++;
      if (imm_ext !== ei) begin n_err++; $display("FAIL rand_imm k=%0d inst=%h got %h want %h", k, inst, imm_ext, ei); end
      n_vec++;
      if (opcode !== 7'(inst % 128) || rd !== 5'((inst >> 7) % 32) || func3 !== 3'((inst >> 12) % 8)
          || func7 !== 7'(inst >> 25)) begin
        n_err++;
        $display("FAIL rand_fields k=%0d inst=%h got %h %h %h %h", k, inst, opcode, rd, func3, func7);
      end
      step();
    end
    wopcode = 7'b1100011;
  endtask

  task automatic test_mid_reset();
    wrd = 5'd9; wdata = 64'h9999; wopcode = 7'b0110011;
    #2 rst = 1'b0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 64'd0;
    #1;
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      inst = r_inst(5'(a), 5'(32 - a)); rs1_addr_control = 5'(a);
      #1;
      n_vec++;
      if (data1 !== 64'd0 || data2 !== 64'd0 || rs1_data_control !== 64'd0) begin
        n_err++;
        $display("FAIL mid_reset x%0d got %h %h %h want 0", a, data1, data2, rs1_data_control);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    wrd = 5'd5; wdata = 64'h1234; wopcode = 7'b0110011;
    step();
    wopcode = 7'b1100011;
    inst = r_inst(5'd5, 5'd9);
    #1;
    n_vec++;
    if (data1 !== 64'h1234) begin n_err++; $display("FAIL reset_x5 got %h want 1234", data1); end
    n_vec++;
    if (data2 !== 64'h9999) begin n_err++; $display("FAIL pending_x9 got %h want 9999", data2); end
  endtask

  task automatic test_gating();
    wrd = 5'd0; wdata = 64'hFF; wopcode = 7'b0110011;
    step();
    wrd = 5'd7; wdata = 64'h77; wopcode = 7'b0110011;
    step();
    wdata = 64'h99; wopcode = 7'b0100011;
    step();
    wopcode = 7'b1100011;
    inst = r_inst(5'd0, 5'd7);
    #1;
    n_vec++;
    if (data1 !== 64'd0) begin n_err++; $display("FAIL gate_x0 got %h want 0", data1); end
    n_vec++;
    if (data2 !== 64'h77) begin n_err++; $display("FAIL gate_store got %h want 77", data2); end
    wdata = 64'h55; wopcode = 7'b0000011;
    step();
    wopcode = 7'b1100011;
    #1;
    n_vec++;
    if (data2 !== 64'h55) begin n_err++; $display("FAIL gate_load got %h want 55", data2); end
  endtask

  task automatic test_bypass();
    wrd = 5'd3; wdata = 64'h10; wopcode = 7'b0010011;
    step();
    wdata = 64'hABCD;
    inst = r_inst(5'd3, 5'd3); rs1_addr_control = 5'd3;
    #1;
    n_vec++;
    if (data1 !== 64'hABCD || data2 !== 64'hABCD || rs1_data_control !== 64'hABCD) begin
      n_err++;
      $display("FAIL bypass got %h %h %h want abcd", data1, data2, rs1_data_control);
    end
    step();
    wopcode = 7'b1100011;
    #1;
    n_vec++;
    if (data1 !== 64'hABCD) begin n_err++; $display("FAIL bypass_landed got %h want abcd", data1); end
  endtask

  task automatic test_imm();
    inst = 32'hFFF00093; #1;
    n_vec++;
    if (imm_ext !== 64'hFFFFFFFFFFFFFFFF || rd !== 5'd1 || func3 !== 3'd0) begin
      n_err++; $display("FAIL imm_addi got %h rd=%0d f3=%0d", imm_ext, rd, func3);
    end
    inst = 32'hFE000EE3; #1;
    n_vec++;
    if (imm_ext !== 64'hFFFFFFFFFFFFFFFC) begin n_err++; $display("FAIL imm_beq got %h want fffffffffffffffc", imm_ext); end
    inst = 32'h800000B7; #1;
    n_vec++;
    if (imm_ext !== 64'hFFFFFFFF80000000) begin n_err++; $display("FAIL imm_lui got %h want ffffffff80000000", imm_ext); end
    inst = 32'h0080006F; #1;
    n_vec++;
    if (imm_ext !== 64'd8) begin n_err++; $display("FAIL imm_jal got %h want 8", imm_ext); end
    inst = 32'h00113423; #1;
    n_vec++;
    if (imm_ext !== 64'd8 || func3 !== 3'd3 || opcode !== 7'b0100011) begin
      n_err++; $display("FAIL imm_sd got %h f3=%0d op=%b", imm_ext, func3, opcode);
    end
  endtask

  task automatic test_fields();
    logic [63:0] va, vb;
    va = {$urandom, $urandom}; vb = {$urandom, $urandom};
    wrd = 5'd10; wdata = va; wopcode = 7'b0111011;
    step();
    wrd = 5'd11; wdata = vb; wopcode = 7'b1101111;
    step();
    wopcode = 7'b1100011;
    inst = 32'h40B50533;
    #1;
    n_vec++;
    if (func7 !== 7'h20 || rd !== 5'd10 || func3 !== 3'd0 || imm_ext !== 64'd0) begin
      n_err++; $display("FAIL fields_sub got f7=%h rd=%0d f3=%0d imm=%h", func7, rd, func3, imm_ext);
    end
    n_vec++;
    if (data1 !== va || data2 !== vb) begin
      n_err++; $display("FAIL fields_ops got %h %h want %h %h", data1, data2, va, vb);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v1, v2;
    v1 = {$urandom, $urandom}; v2 = ~v1;
    wrd = 5'd4; wdata = v1; wopcode = 7'b0110111;
    step();
    wdata = v2; wopcode = 7'b0010111; inst = r_inst(5'd4, 5'd4);
    #1;
    n_vec++;
    if (data1 !== v2) begin n_err++; $display("FAIL b2b_bypass got %h want %h", data1, v2); end
    step();
    wopcode = 7'b1100011;
    #1;
    n_vec++;
    if (data2 !== v2) begin n_err++; $display("FAIL b2b_landed got %h want %h", data2, v2); end
    test_random(400);
  endtask

  initial begin
    test_reset();
    test_random(300);
    test_mid_reset();
    test_gating();
    test_bypass();
    test_imm();
    test_fields();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the RV64I pipelined CPU. It splits the fetched 32-bit instruction into its fields, produces the sign-extended immediate, and holds the 32×64-bit integer register file. The register file has two operand read ports, one extra read port for control logic (branch/jump target resolution), and one write-back port driven by the WB stage. The block sits between IF (which supplies `inst`) and EX (which consumes the fields, operands and immediate).

## Interface
Parameters: none. Opcode constants come from the shared package.

- clk  in  1  clock; all register-file writes occur on its rising edge
- rst  in  1  asynchronous, active-low reset
- inst  in  32  instruction in decode
- wdata  in  64  write-back data
- wrd  in  5  write-back destination register
- wopcode  in  7  opcode of the write-back instruction; gates the write
- rs1_addr_control  in  5  register address for the control read port
- opcode  out  7  inst[6:0]
- rd  out  5  inst[11:7]
- func3  out  3  inst[14:12]
- func7  out  7  inst[31:25]
- data1  out  64  register[inst[19:15]]
- data2  out  64  register[inst[24:20]]
- imm_ext  out  64  sign-extended immediate
- rs1_data_control  out  64  register[rs1_addr_control]

## Operation
- Field outputs are pure slices of `inst`, independent of opcode.
- Register file: 32 entries × 64 bits. x0 always reads 0 and is never written.
- Write enable = (`wrd` != 0) AND `wopcode` ∈ {OP 0110011, OP-IMM 0010011, LOAD 0000011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, OP-32 0111011, OP-IMM-32 0011011}.
- STORE, BRANCH and unknown opcodes never write.
- Read ports (data1, data2, rs1_data_control) are combinational, with write-through bypass: when the write enable is active and `wrd` equals the read address, the port returns `wdata`. x0 still returns 0.
- imm_ext, selected by opcode, always sign-extended from inst[31]:
  - I-type (LOAD, OP-IMM, OP-IMM-32, JALR): inst[31:20]
  - S-type (STORE 0100011): {inst[31:25], inst[11:7]}
  - B-type (BRANCH 1100011): {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U-type (LUI, AUIPC): {inst[31:12], 12'b0}, then sign-extended to 64 bits
  - J-type (JAL): {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - R-type and unknown opcodes: 0

## Timing
- All outputs are combinational from `inst`, `rs1_addr_control` and register state, plus the bypass from `wdata`/`wrd`/`wopcode`. Latency is zero.
- A write lands on the rising edge of `clk`. Because of the bypass, a read of the same register in the same cycle already sees `wdata`.
- `rst` low clears all 32 registers to 0 immediately, without waiting for a clock edge. While `rst` is low, all data read outputs are 0 and writes are ignored. Field outputs and imm_ext keep tracking `inst`.
- `rst` deasserting while a write is pending: the write takes effect on the first rising edge with `rst` high.
- Simultaneous write and any number of reads of the same register: every port returns `wdata`.

## Structure
- Shared package `rv64_pkg`: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, OP_32, OP_IMM_32) and the write-enable decode function, shared with the control unit.
- Sub-module `regfile`: 32×64, two read ports plus one control read port, one write port, async active-low clear, bypass logic.
- Field slicing and immediate generation stay at the top level.

## Test plan
- Reset: assert `rst`=0 mid-simulation; data1 and data2 read 0 for every address (x1..x31). Deassert, then write x5=0x1234 with wopcode=0110011; a read of x5 returns 0x1234.
- Write gating:
  - wrd=0, wopcode=0110011, wdata=0xFF leaves x0 reading 0.
  - wopcode=0100011 (STORE) leaves x7 unchanged.
  - wopcode=0000011 (LOAD) updates x7.
- Bypass: with x3 holding 0x10, drive wrd=3, wdata=0xABCD, wopcode=0010011, and inst with rs1=rs2=3. Before the edge, data1, data2 and rs1_data_control (with rs1_addr_control=3) all read 0xABCD.
- Immediates:
  - inst=0xFFF00093 (addi x1,x0,-1): imm_ext=0xFFFFFFFFFFFFFFFF, rd=1, func3=0.
  - inst=0xFE000EE3 (beq, offset −4): imm_ext=0xFFFFFFFFFFFFFFFC.
  - inst=0x800000B7 (lui): imm_ext=0xFFFFFFFF80000000.
  - inst=0x0080006F (jal +8): imm_ext=8.
- S-type: inst=0x00113423 (sd x1,8(x2)) gives imm_ext=8, func3=3, opcode=0100011.
- Fields: inst=0x40B50533 (sub x10,x10,x11) gives func7=0x20, rd=10, func3=0, data1=x10 value, data2=x11 value, imm_ext=0.
